// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM encoding, legal oversampling ratios
// and parity-type constants common to the TX and RX sides.
package uart_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
      ST_PARITY,
      ST_STOP
   } rx_state_e;

   localparam int unsigned PRESCALE_8  = 8;
   localparam int unsigned PRESCALE_16 = 16;
   localparam int unsigned PRESCALE_32 = 32;

   localparam logic PAR_EVEN = 1'b0;
   localparam logic PAR_ODD  = 1'b1;

endpackage

// File: rtl/uart_rx_sampler.sv
// RX line synchronizer, per-bit edge counter and mid-bit sampling.
// UART_RX_MAJORITY_VOTE_EN selects a 2-of-3 vote around the bit centre.
module uart_rx_sampler
   import uart_pkg::*;
#(
   parameter int PRESCALE_WIDTH = 6
) (
   input  logic                      CLK,
   input  logic                      RST,
   input  logic                      RX_IN,
   input  logic [PRESCALE_WIDTH-1:0] i_prescale,
   input  logic                      i_idle,
   output logic                      o_rx_s,
   output logic                      o_sampled_bit,
   output logic                      o_bit_done
);

   localparam logic [PRESCALE_WIDTH-1:0] ONE = PRESCALE_WIDTH'(1);
   localparam logic [PRESCALE_WIDTH-1:0] TWO = PRESCALE_WIDTH'(2);

   logic [1:0]                r_sync;
   logic [PRESCALE_WIDTH-1:0] r_edge_cnt;
   logic                      r_bit;
   logic                      w_rx_s;
   logic [PRESCALE_WIDTH-1:0] w_half;

   assign w_rx_s        = r_sync[1];
   assign w_half        = i_prescale >> 1;
   assign o_rx_s        = w_rx_s;
   assign o_sampled_bit = r_bit;
   assign o_bit_done    = !i_idle && (r_edge_cnt == (i_prescale - ONE));

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) r_sync <= 2'b11;
      else     r_sync <= {r_sync[0], RX_IN};
   end

   // The cycle IDLE sees the line low already counts as edge 0 of the start bit.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST)             r_edge_cnt <= '0;
      else if (i_idle)     r_edge_cnt <= {{(PRESCALE_WIDTH-1){1'b0}}, ~w_rx_s};
      else if (o_bit_done) r_edge_cnt <= '0;
      else                 r_edge_cnt <= r_edge_cnt + ONE;
   end

`ifdef UART_RX_MAJORITY_VOTE_EN
   logic [1:0] r_vote;

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         r_vote <= 2'b11;
         r_bit  <= 1'b1;
      end else begin
         if (r_edge_cnt == (w_half - TWO)) r_vote[0] <= w_rx_s;
         if (r_edge_cnt == (w_half - ONE)) r_vote[1] <= w_rx_s;
         if (r_edge_cnt == w_half)
            r_bit <= (r_vote[0] & r_vote[1]) | (r_vote[0] & w_rx_s) | (r_vote[1] & w_rx_s);
      end
   end
`else
   always_ff @(posedge CLK or posedge RST) begin
      if (RST)                               r_bit <= 1'b1;
      else if (r_edge_cnt == (w_half - ONE)) r_bit <= w_rx_s;
   end
`endif

endmodule

// File: rtl/uart_rx.sv
// UART receiver: frame FSM, LSB-first deserializer, parity/stop checking.
// Build option UART_RX_MAJORITY_VOTE_EN is handled inside uart_rx_sampler.
module uart_rx
   import uart_pkg::*;
#(
   parameter int P_DATA_WIDTH   = 8,
   parameter int PRESCALE_WIDTH = 6
) (
   input  logic                      CLK,
   input  logic                      RST,
   input  logic                      RX_IN,
   input  logic [PRESCALE_WIDTH-1:0] PRESCALE,
   input  logic                      PAR_EN,
   input  logic                      PAR_TYP,
   output logic [P_DATA_WIDTH-1:0]   P_DATA,
   output logic                      Data_Valid,
   output logic                      parity_error,
   output logic                      stop_error
);

   localparam int BCW = (P_DATA_WIDTH > 1) ? $clog2(P_DATA_WIDTH) : 1;
   localparam logic [BCW-1:0] LAST_BIT = BCW'(P_DATA_WIDTH - 1);

   rx_state_e                 r_state, w_state_nxt;
   logic [PRESCALE_WIDTH-1:0] r_prescale;
   logic                      r_par_en, r_par_typ, r_par_err;
   logic [P_DATA_WIDTH-1:0]   r_shift;
   logic [BCW-1:0]            r_bit_cnt;
   logic                      w_rx_s, w_bit, w_bit_done;
   logic                      w_shift_en, w_par_chk, w_resolve;

   uart_rx_sampler #(.PRESCALE_WIDTH(PRESCALE_WIDTH)) u_sampler (
      .CLK           (CLK),
      .RST           (RST),
      .RX_IN         (RX_IN),
      .i_prescale    (r_prescale),
      .i_idle        (r_state == ST_IDLE),
      .o_rx_s        (w_rx_s),
      .o_sampled_bit (w_bit),
      .o_bit_done    (w_bit_done)
   );

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) r_state <= ST_IDLE;
      else     r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      w_shift_en  = 1'b0;
      w_par_chk   = 1'b0;
      w_resolve   = 1'b0;
      case (r_state)
         ST_IDLE:   if (!w_rx_s) w_state_nxt = ST_START;
         ST_START:  if (w_bit_done) w_state_nxt = w_bit ? ST_IDLE : ST_DATA;
         ST_DATA:
            if (w_bit_done) begin
               w_shift_en = 1'b1;
               if (r_bit_cnt == LAST_BIT) w_state_nxt = r_par_en ? ST_PARITY : ST_STOP;
            end
         ST_PARITY:
            if (w_bit_done) begin
               w_par_chk   = 1'b1;
               w_state_nxt = ST_STOP;
            end
         ST_STOP:
            if (w_bit_done) begin
               w_resolve   = 1'b1;
               w_state_nxt = ST_IDLE;
            end
         default:   w_state_nxt = ST_IDLE;
      endcase
   end

   // Frame configuration is frozen once a start bit is seen.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         r_prescale   <= PRESCALE_WIDTH'(PRESCALE_8);
         r_par_en     <= 1'b0;
         r_par_typ    <= PAR_EVEN;
         r_par_err    <= 1'b0;
         r_shift      <= '0;
         r_bit_cnt    <= '0;
         P_DATA       <= '0;
         Data_Valid   <= 1'b0;
         parity_error <= 1'b0;
         stop_error   <= 1'b0;
      end else begin
         Data_Valid   <= 1'b0;
         parity_error <= 1'b0;
         stop_error   <= 1'b0;
         if (r_state == ST_IDLE) begin
            r_prescale <= PRESCALE;
            r_par_en   <= PAR_EN;
            r_par_typ  <= PAR_TYP;
            r_par_err  <= 1'b0;
            r_bit_cnt  <= '0;
         end
         if (w_shift_en) begin
            r_shift   <= {w_bit, r_shift[P_DATA_WIDTH-1:1]};
            r_bit_cnt <= r_bit_cnt + BCW'(1);
         end
         if (w_par_chk)
            r_par_err <= w_bit != ((^r_shift) ^ (r_par_typ == PAR_ODD));
         if (w_resolve) begin
            stop_error   <= !w_bit;
            parity_error <= r_par_err;
            if (w_bit && !r_par_err) begin
               P_DATA     <= r_shift;
               Data_Valid <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: line waveforms are built per cycle, a
// waveform-level reference model predicts strobes, a monitor compares them.
module tb_uart_rx;

   localparam int W  = 8;
   localparam int PW = 6;

   logic          CLK = 1'b0;
   logic          RST = 1'b1;
   logic          RX_IN = 1'b1;
   logic [PW-1:0] PRESCALE = PW'(8);
   logic          PAR_EN = 1'b0;
   logic          PAR_TYP = 1'b0;
   logic [W-1:0]  P_DATA;
   logic          Data_Valid, parity_error, stop_error;

   uart_rx #(.P_DATA_WIDTH(W), .PRESCALE_WIDTH(PW)) dut (
      .CLK          (CLK),
      .RST          (RST),
      .RX_IN        (RX_IN),
      .PRESCALE     (PRESCALE),
      .PAR_EN       (PAR_EN),
      .PAR_TYP      (PAR_TYP),
      .P_DATA       (P_DATA),
      .Data_Valid   (Data_Valid),
      .parity_error (parity_error),
      .stop_error   (stop_error)
   );

   always #5 CLK = ~CLK;

   int cyc = 0;
   always @(posedge CLK) cyc <= cyc + 1;

   typedef struct {
      logic         dv, pe, se;
      logic [W-1:0] data;
      int           edge_n;
   } exp_t;

   exp_t         expq[$];
   bit           wave[$];
   logic [W-1:0] m_pdata = '0;
   int           vectors = 0;
   int           miscompares = 0;

   task automatic check(input string nm, input logic [31:0] got, input logic [31:0] req);
      vectors++;
      if (got !== req) begin
         miscompares++;
         $display("FAIL %s: got %0h, required %0h", nm, got, req);
      end
   endtask

   function automatic bit lvl(input int j);
      return (j >= 0 && j < wave.size()) ? wave[j] : 1'b1;
   endfunction

   // Value of the bit whose cell starts at waveform index j.
   function automatic bit smp(input int j, input int p);
`ifdef UART_RX_MAJORITY_VOTE_EN
      int ones;
      ones = int'(lvl(j + p/2 - 2)) + int'(lvl(j + p/2 - 1)) + int'(lvl(j + p/2));
      return ones >= 2;
`else
      return lvl(j + p/2 - 1);
`endif
   endfunction

   // Line level wave[i] is applied right after edge base+i; the receiver sees
   // it two flops later, so a low at index j is first acted on at edge base+3+j.
   task automatic model_run(input int base, input int p, input bit pe, input bit pt);
      int j;
      int len;
      j   = 0;
      len = (W + 2 + int'(pe)) * p;
      while (j < wave.size()) begin
         if (wave[j]) j++;
         else if (smp(j, p)) j += p;
         else if (j + len > wave.size()) j = wave.size();
         else begin
            logic [W-1:0] d;
            bit           par_bad, stop_bad;
            exp_t         e;
            for (int b = 0; b < W; b++) d[b] = smp(j + (b + 1) * p, p);
            par_bad  = pe && (smp(j + (W + 1) * p, p) != ((^d) ^ pt));
            stop_bad = !smp(j + (W + 1 + int'(pe)) * p, p);
            e.dv = !par_bad && !stop_bad;
            e.pe = par_bad;
            e.se = stop_bad;
            if (e.dv) m_pdata = d;
            e.data   = m_pdata;
            e.edge_n = base + 3 + j + len - 1;
            expq.push_back(e);
            j += len;
         end
      end
   endtask

   task automatic add_idle(input int n);
      repeat (n) wave.push_back(1'b1);
   endtask

   task automatic add_frame(input int p, input logic [W-1:0] d, input bit pe, input bit pt,
                            input bit bad_par, input bit bad_stop);
      repeat (p) wave.push_back(1'b0);
      for (int b = 0; b < W; b++) repeat (p) wave.push_back(d[b]);
      if (pe) repeat (p) wave.push_back((^d) ^ pt ^ bad_par);
      repeat (p) wave.push_back(!bad_stop);
   endtask

   // Called at #1 after a rising edge; consumes and clears the waveform.
   task automatic drive(input int p, input bit pe, input bit pt, input bit pad);
      int base;
      PRESCALE = PW'(p);
      PAR_EN   = pe;
      PAR_TYP  = pt;
      if (pad) add_idle(8);
      base = cyc;
      model_run(base, p, pe, pt);
      foreach (wave[i]) begin
         RX_IN = wave[i];
         @(posedge CLK);
         #1;
      end
      wave.delete();
   endtask

   initial begin
      exp_t e;
      forever begin
         @(negedge CLK);
         if (!RST && (Data_Valid || parity_error || stop_error)) begin
            vectors++;
            if (expq.size() == 0) begin
               miscompares++;
               $display("FAIL unexpected_strobe: got dv=%b pe=%b se=%b data=%h at edge %0d, required no strobe",
                        Data_Valid, parity_error, stop_error, P_DATA, cyc);
            end else begin
               e = expq.pop_front();
               if ({Data_Valid, parity_error, stop_error} !== {e.dv, e.pe, e.se} ||
                   P_DATA !== e.data || cyc != e.edge_n) begin
                  miscompares++;
                  $display("FAIL frame: got dv=%b pe=%b se=%b data=%h edge %0d, required dv=%b pe=%b se=%b data=%h edge %0d",
                           Data_Valid, parity_error, stop_error, P_DATA, cyc,
                           e.dv, e.pe, e.se, e.data, e.edge_n);
               end
            end
         end
      end
   end

   initial begin
      logic [W-1:0] gl_exp;
      RST = 1'b1;
      repeat (3) @(posedge CLK);
      #1;
      check("reset_p_data", 32'(P_DATA), 0);
      check("reset_data_valid", 32'(Data_Valid), 0);
      check("reset_parity_error", 32'(parity_error), 0);
      check("reset_stop_error", 32'(stop_error), 0);
      RST = 1'b0;
      @(posedge CLK);
      #1;

      // Good frame, no parity
      add_idle(3);
      add_frame(8, 8'hA5, 1'b0, 1'b0, 1'b0, 1'b0);
      drive(8, 1'b0, 1'b0, 1'b1);
      check("p_data_a5", 32'(P_DATA), 32'hA5);

      // Odd parity: correct, then wrong parity bit
      add_idle(2);
      add_frame(16, 8'h6B, 1'b1, 1'b1, 1'b0, 1'b0);
      add_idle(3);
      add_frame(16, 8'h6B, 1'b1, 1'b1, 1'b1, 1'b0);
      drive(16, 1'b1, 1'b1, 1'b1);
      check("p_data_hold_after_parity_err", 32'(P_DATA), 32'h6B);

      // Stop error followed immediately by a good frame
      add_idle(2);
      add_frame(8, 8'h5A, 1'b0, 1'b0, 1'b0, 1'b1);
      add_frame(8, 8'h3C, 1'b0, 1'b0, 1'b0, 1'b0);
      drive(8, 1'b0, 1'b0, 1'b1);

      // Two-cycle start glitch, real frame right as the receiver is idle again
      add_idle(4);
      wave.push_back(1'b0);
      wave.push_back(1'b0);
      add_idle(14);
      add_frame(16, 8'hC3, 1'b0, 1'b0, 1'b0, 1'b0);
      drive(16, 1'b0, 1'b0, 1'b1);
      check("p_data_after_glitch", 32'(P_DATA), 32'hC3);

      // One-cycle inversion at the centre of data bit 3
      add_idle(3);
      add_frame(16, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b0);
      wave[3 + 4*16 + 7] = 1'b0;
      drive(16, 1'b0, 1'b0, 1'b1);
`ifdef UART_RX_MAJORITY_VOTE_EN
      gl_exp = 8'hFF;
`else
      gl_exp = 8'hF7;
`endif
      check("mid_bit_glitch", 32'(P_DATA), 32'(gl_exp));

      // Randomized frames, gaps, glitches and errors at every legal ratio
      for (int rep = 0; rep < 3; rep++) begin
         for (int k = 0; k < 3; k++) begin
            int p;
            bit pe, pt;
            p  = 8 << k;
            pe = bit'($urandom_range(0, 1));
            pt = bit'($urandom_range(0, 1));
            for (int f = 0; f < 4; f++) begin
               add_idle(int'($urandom_range(0, 3)));
               if ($urandom_range(0, 4) == 0) begin
                  repeat (int'($urandom_range(1, p/2 - 2))) wave.push_back(1'b0);
                  add_idle(p);
               end
               add_frame(p, W'($urandom), pe, pt,
                         pe && ($urandom_range(0, 3) == 0), $urandom_range(0, 4) == 0);
            end
            drive(p, pe, pt, 1'b1);
         end
      end

      // Back-to-back frames, then reset in the middle of a third one
      add_idle(2);
      add_frame(32, 8'h5A, 1'b0, 1'b0, 1'b0, 1'b0);
      add_frame(32, 8'h6B, 1'b0, 1'b0, 1'b0, 1'b0);
      add_frame(32, 8'h3C, 1'b0, 1'b0, 1'b0, 1'b0);
      repeat (6 * 32) void'(wave.pop_back());
      drive(32, 1'b0, 1'b0, 1'b0);
      check("p_data_before_reset", 32'(P_DATA), 32'h6B);
      RX_IN = 1'b1;
      RST   = 1'b1;
      #1;
      check("midframe_reset_p_data", 32'(P_DATA), 0);
      check("midframe_reset_strobes", 32'({Data_Valid, parity_error, stop_error}), 0);
      m_pdata = '0;
      repeat (3) @(posedge CLK);
      #1;
      RST = 1'b0;
      @(posedge CLK);
      #1;

      // Recovery after reset
      add_idle(20);
      add_frame(32, 8'h96, 1'b0, 1'b0, 1'b0, 1'b0);
      drive(32, 1'b0, 1'b0, 1'b1);
      check("p_data_after_reset", 32'(P_DATA), 32'h96);

      repeat (5) @(posedge CLK);
      #1;
      while (expq.size() > 0) begin
         exp_t m;
         m = expq.pop_front();
         vectors++;
         miscompares++;
         $display("FAIL missing_strobe: got none, required dv=%b pe=%b se=%b data=%h at edge %0d",
                  m.dv, m.pe, m.se, m.data, m.edge_n);
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
